// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: request types, fault causes,
// FSM state codes and the default RAM base address.
package mem_access_pkg;

   // Request types driven by the CPU control
   localparam logic [1:0] REQ_FETCH    = 2'b00;
   localparam logic [1:0] REQ_LOAD     = 2'b01;
   localparam logic [1:0] REQ_STORE    = 2'b10;
   localparam logic [1:0] REQ_RESERVED = 2'b11;

   // Fault causes reported with a response
   localparam logic [1:0] CAUSE_NONE       = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
   localparam logic [1:0] CAUSE_ACCESS     = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL    = 2'b11;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // First RAM byte address; ROM starts at zero
   localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1000_0000;

endpackage

// File: rtl/mem_region_check.sv
// Combinational legality check of a memory request: type, alignment and
// region. Kept standalone so exception logic can reuse the same rules.
module mem_region_check
   import mem_access_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               MEMORY_DEPTH = 64,
   parameter int               ROM_DEPTH    = 64,
   parameter logic [WIDTH-1:0] DATA_BASE    = DEFAULT_DATA_BASE
) (
   input  logic [WIDTH-1:0] addr_i,
   input  logic [1:0]       type_i,
   output logic             fault_o,
   output logic [1:0]       cause_o
);

   // Limits carry one extra bit so DATA_BASE + RAM size cannot wrap around
   localparam logic [WIDTH:0] ROM_LIMIT = (WIDTH+1)'(4 * ROM_DEPTH);
   localparam logic [WIDTH:0] RAM_BASE  = {1'b0, DATA_BASE};
   localparam logic [WIDTH:0] RAM_LIMIT = RAM_BASE + (WIDTH+1)'(4 * MEMORY_DEPTH);

   logic [WIDTH:0] addr_ext;
   logic           in_rom;
   logic           in_ram;
   logic           violation;

   assign addr_ext = {1'b0, addr_i};
   assign in_rom   = (addr_ext < ROM_LIMIT);
   assign in_ram   = (addr_ext >= RAM_BASE) && (addr_ext < RAM_LIMIT);

   // Stores may only hit RAM, fetches only ROM, loads either
   assign violation = !(in_rom || in_ram)
                   || ((type_i == REQ_STORE) && in_rom)
                   || ((type_i == REQ_FETCH) && in_ram);

   // Priority: illegal type, then misalignment, then region violation
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      fault_o = 1'b0;
      cause_o = CAUSE_NONE;
      if (type_i == REQ_RESERVED) begin
         fault_o = 1'b1;
         cause_o = CAUSE_ILLEGAL;
      end else if (addr_i[1:0] != 2'b00) begin
         fault_o = 1'b1;
         cause_o = CAUSE_MISALIGNED;
      end else if (violation) begin
         fault_o = 1'b1;
         cause_o = CAUSE_ACCESS;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Sequencing front-end for the unified ROM/RAM memory system. Accepts one
// request at a time, performs the access in a single cycle, latches fetched
// data into IR or loaded data into MDR, and holds the response until taken.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               MEMORY_DEPTH = 64,
   parameter int               ROM_DEPTH    = 64,
   parameter logic [WIDTH-1:0] DATA_BASE    = DEFAULT_DATA_BASE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_type_i,
   input  logic [WIDTH-1:0] req_addr_i,
   input  logic [WIDTH-1:0] req_wdata_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_fault_o,
   output logic [1:0]       fault_cause_o,
   output logic [WIDTH-1:0] resp_data_o,
   output logic [WIDTH-1:0] instruction_o,
   output logic [WIDTH-1:0] mem_data_o,
   output logic [WIDTH-1:0] mem_address_o,
   output logic             mem_write_enable_o,
   output logic [WIDTH-1:0] mem_write_data_o,
   input  logic [WIDTH-1:0] mem_read_data_i,
   output logic [WIDTH-1:0] fetch_count_o
);

   logic [1:0]       state_q, state_d;
   logic [1:0]       type_q, type_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             fault_q, fault_d;
   logic [1:0]       cause_q, cause_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;
   logic [WIDTH-1:0] count_q, count_d;

   logic             chk_fault;
   logic [1:0]       chk_cause;

   // The check runs on the live request so its verdict is latched on accept
   mem_region_check #(
      .WIDTH        (WIDTH),
      .MEMORY_DEPTH (MEMORY_DEPTH),
      .ROM_DEPTH    (ROM_DEPTH),
      .DATA_BASE    (DATA_BASE)
   ) u_region_check (
      .addr_i  (req_addr_i),
      .type_i  (req_type_i),
      .fault_o (chk_fault),
      .cause_o (chk_cause)
   );

   // Next-state logic for the IDLE -> ACCESS -> RESP sequence
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fault_d = fault_q;
      cause_d = cause_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               type_d  = req_type_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               fault_d = chk_fault;
               cause_d = chk_cause;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // A faulted request leaves IR, MDR and the fetch counter alone
            if (!fault_q) begin
               if (type_q == REQ_FETCH) begin
                  ir_d    = mem_read_data_i;
                  count_d = count_q + WIDTH'(1);
               end else if (type_q == REQ_LOAD) begin
                  mdr_d = mem_read_data_i;
               end
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         // NOTE: IR and MDR are plain registers, not a memory array, so they are cleared like any other state.
         state_q <= ST_IDLE;
         type_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
         ir_q    <= '0;
         mdr_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         count_q <= count_d;
      end
   end

   // Response payload: IR for fetch, MDR for load, zero for store or fault
   always_comb begin
      resp_data_o = '0;
      if (!fault_q) begin
         if (type_q == REQ_FETCH) begin
            resp_data_o = ir_q;
         end else if (type_q == REQ_LOAD) begin
            resp_data_o = mdr_q;
         end
      end
   end

   assign req_ready_o   = (state_q == ST_IDLE);
   assign resp_valid_o  = (state_q == ST_RESP);
   assign resp_fault_o  = fault_q;
   assign fault_cause_o = cause_q;
   assign instruction_o = ir_q;
   assign mem_data_o    = mdr_q;
   assign fetch_count_o = count_q;

   // Memory interface: address held in every state, write only in ACCESS.
   // Reset gates the strobe directly so a store caught by reset never commits.
   assign mem_address_o      = addr_q;
   assign mem_write_data_o   = wdata_q;
   assign mem_write_enable_o = (state_q == ST_ACCESS) && (type_q == REQ_STORE)
                            && !fault_q && !reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small ROM/RAM model and a
// response scoreboard filled at issue time and drained at each response.
module tb_mem_access_unit;

   typedef struct {
      logic        fault;
      logic [1:0]  cause;
      logic [31:0] data;
   } resp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_fault;
   logic [1:0]  fault_cause;
   logic [31:0] resp_data;
   logic [31:0] instruction;
   logic [31:0] mem_data;
   logic [31:0] mem_address;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] fetch_count;

   logic [31:0] rom [64];
   logic [31:0] ram [64];
   logic        init_mem;
   int          we_cnt = 0;

   resp_t exp_q [$];
   int    pass_cnt  = 0;
   int    total_cnt = 0;

   mem_access_unit dut (
      .clock              (clock),
      .reset              (reset),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_type_i         (req_type),
      .req_addr_i         (req_addr),
      .req_wdata_i        (req_wdata),
      .resp_valid_o       (resp_valid),
      .resp_ready_i       (resp_ready),
      .resp_fault_o       (resp_fault),
      .fault_cause_o      (fault_cause),
      .resp_data_o        (resp_data),
      .instruction_o      (instruction),
      .mem_data_o         (mem_data),
      .mem_address_o      (mem_address),
      .mem_write_enable_o (mem_we),
      .mem_write_data_o   (mem_wdata),
      .mem_read_data_i    (mem_rdata),
      .fetch_count_o      (fetch_count)
   );

   always #5 clock = ~clock;

   // Memory system model: combinational read, RAM written on the clock edge
   always_comb begin
      mem_rdata = 32'h0;
      if (mem_address < 32'h0000_0100) begin
         mem_rdata = rom[mem_address[7:2]];
      end else if (mem_address >= 32'h1000_0000 && mem_address < 32'h1000_0100) begin
         mem_rdata = ram[mem_address[7:2]];
      end
   end

   always @(posedge clock) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) ram[i] <= 32'h5500_0000 + 32'(i);
      end else if (mem_we && mem_address >= 32'h1000_0000 && mem_address < 32'h1000_0100) begin
         ram[mem_address[7:2]] <= mem_wdata;
      end
   end

   always @(posedge clock) begin
      if (mem_we) we_cnt <= we_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Offer one request, wait for its response and compare against the scoreboard
   task automatic issue(input string tag, input logic [1:0] t, input logic [31:0] a,
                        input logic [31:0] wd, input logic ef, input logic [1:0] ec,
                        input logic [31:0] ed);
      resp_t e;
      resp_t got;
      int    wt;
      int    lat;
      e.fault = ef;
      e.cause = ec;
      e.data  = ed;
      exp_q.push_back(e);
      wt = 0;
      while (!req_ready && wt < 20) begin
         @(posedge clock); #1;
         wt++;
      end
      req_type  = t;
      req_addr  = a;
      req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd2);
      got = exp_q.pop_front();
      check({tag, "_fault"}, {31'b0, resp_fault}, {31'b0, got.fault});
      check({tag, "_cause"}, {30'b0, fault_cause}, {30'b0, got.cause});
      check({tag, "_data"}, resp_data, got.data);
   endtask

   task automatic release_resp();
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
   endtask

   int          we_before;
   logic [31:0] rom_word4;

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + 32'(i);
      rom[1]     = 32'h2008_0005;
      rom_word4  = rom[4];
      reset      = 1'b1;
      init_mem   = 1'b1;
      req_valid  = 1'b0;
      req_type   = 2'b00;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset    = 1'b0;
      init_mem = 1'b0;

      // Reset state
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_fault", {31'b0, resp_fault}, 32'd0);
      check("rst_cause", {30'b0, fault_cause}, 32'd0);
      check("rst_ir", instruction, 32'h0);
      check("rst_mdr", mem_data, 32'h0);
      check("rst_count", fetch_count, 32'h0);
      check("rst_we", {31'b0, mem_we}, 32'd0);
      check("rst_addr", mem_address, 32'h0);

      // Fetch from ROM word 1
      issue("fetch4", 2'b00, 32'h0000_0004, 32'h0, 1'b0, 2'b00, 32'h2008_0005);
      check("fetch4_ir", instruction, 32'h2008_0005);
      check("fetch4_count", fetch_count, 32'd1);
      release_resp();

      // Store then load back through RAM
      we_before = we_cnt;
      issue("store8", 2'b10, 32'h1000_0008, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0);
      release_resp();
      check("store8_we_cycles", 32'(we_cnt - we_before), 32'd1);
      check("store8_ram", ram[2], 32'hDEAD_BEEF);
      issue("load8", 2'b01, 32'h1000_0008, 32'h0, 1'b0, 2'b00, 32'hDEAD_BEEF);
      check("load8_mdr", mem_data, 32'hDEAD_BEEF);
      check("load8_ir_kept", instruction, 32'h2008_0005);
      release_resp();

      // Store into ROM faults and never strobes write enable
      we_before = we_cnt;
      issue("store_rom", 2'b10, 32'h0000_0010, 32'h1111_2222, 1'b1, 2'b10, 32'h0);
      release_resp();
      check("store_rom_we", 32'(we_cnt - we_before), 32'd0);
      check("store_rom_rom", rom[4], rom_word4);
      check("store_rom_mdr_kept", mem_data, 32'hDEAD_BEEF);
      check("store_rom_count_kept", fetch_count, 32'd1);

      // Fault priority and RAM upper boundary
      issue("illegal_type", 2'b11, 32'h1000_0002, 32'h0, 1'b1, 2'b11, 32'h0);
      release_resp();
      issue("misaligned", 2'b01, 32'h1000_0002, 32'h0, 1'b1, 2'b01, 32'h0);
      release_resp();
      issue("ram_past_end", 2'b01, 32'h1000_0100, 32'h0, 1'b1, 2'b10, 32'h0);
      release_resp();
      issue("ram_last", 2'b01, 32'h1000_00FC, 32'h0, 1'b0, 2'b00, 32'h5500_003F);
      release_resp();

      // Fetch from RAM is illegal; loads from ROM are legal; ROM boundary
      issue("fetch_ram", 2'b00, 32'h1000_0000, 32'h0, 1'b1, 2'b10, 32'h0);
      release_resp();
      issue("load_rom", 2'b01, 32'h0000_0008, 32'h0, 1'b0, 2'b00, rom[2]);
      release_resp();
      issue("fetch_rom_last", 2'b00, 32'h0000_00FC, 32'h0, 1'b0, 2'b00, rom[63]);
      release_resp();
      check("fetch_rom_last_count", fetch_count, 32'd2);
      issue("fetch_rom_past", 2'b00, 32'h0000_0100, 32'h0, 1'b1, 2'b10, 32'h0);
      release_resp();
      check("fetch_rom_past_ir_kept", instruction, rom[63]);
      check("fetch_rom_past_count", fetch_count, 32'd2);

      // Held response: stable, not ready, competing request ignored
      issue("hold", 2'b01, 32'h1000_0008, 32'h0, 1'b0, 2'b00, 32'hDEAD_BEEF);
      req_type  = 2'b00;
      req_addr  = 32'h0000_0004;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         check("hold_valid", {31'b0, resp_valid}, 32'd1);
         check("hold_ready", {31'b0, req_ready}, 32'd0);
         check("hold_data", resp_data, 32'hDEAD_BEEF);
         check("hold_addr", mem_address, 32'h1000_0008);
      end
      req_valid = 1'b0;
      release_resp();
      check("hold_idle", {31'b0, req_ready}, 32'd1);
      check("hold_count", fetch_count, 32'd2);

      // Reset during the ACCESS cycle of a store
      we_before = we_cnt;
      req_type  = 2'b10;
      req_addr  = 32'h1000_0000;
      req_wdata = 32'hCAFE_F00D;
      req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      check("rst_access_we", {31'b0, mem_we}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_access_ram", ram[0], 32'h5500_0000);
      check("rst_access_we_cycles", 32'(we_cnt - we_before), 32'd0);
      check("rst_access_idle", {31'b0, req_ready}, 32'd1);
      check("rst_access_resp", {31'b0, resp_valid}, 32'd0);
      check("rst_access_ir", instruction, 32'h0);
      check("rst_access_mdr", mem_data, 32'h0);
      check("rst_access_count", fetch_count, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
